// File: rtl/fadd_pipe.sv
// Pipelined IEEE-754 add/subtract (RNE, full denormals, NaN/Inf specials) with a tag carried alongside.
// Latency: 3 cycles from accept to out_valid; sustains 1 op/cycle.
// Backpressure: out_valid & ~out_ready freezes all stages and drops in_ready (no bubble collapsing).
//
// Ports:
//   clk, rst           clock; synchronous active-high reset (clears valids, rd, out_tag)
//   in_valid/in_ready  operand handshake; rs1, rs2, op_sub (1: rs1-rs2), in_tag
//   out_valid/out_ready result handshake; rd, out_tag (held stable while stalled)
module fadd_pipe #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int TAGW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW+MW:0]   rs1,
    input  logic [EW+MW:0]   rs2,
    input  logic             op_sub,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   rd,
    output logic [TAGW-1:0]  out_tag
);
    localparam int W  = 1 + EW + MW;
    localparam int XW = MW + 3;          // hidden + fraction + guard + round
    localparam int MX = MW + 4;          // XW plus sticky
    localparam logic [EW-1:0] EONES = '1;
    localparam logic [MW-1:0] QBIT  = {1'b1, {(MW-1){1'b0}}};

    logic stall;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // ---------------- stage 1: unpack, order, align ----------------
    logic              s1_sa, s1_sb, s1_a_nan, s1_b_nan, s1_a_inf, s1_b_inf, s1_a_ge;
    logic [EW-1:0]     s1_ea, s1_eb, s1_eaf, s1_ebf, s1_ebig, s1_esm, s1_diff;
    logic [MW-1:0]     s1_fa, s1_fb;
    logic [MW:0]       s1_ma, s1_mb, s1_mbig, s1_msm;
    logic [31:0]       s1_sh;
    logic [2*XW-1:0]   s1_wide;

    logic              sgn1_d, sub1_d, zs1_d, spec1_d;
    logic [W-1:0]      specw1_d;
    logic [MX-1:0]     mb1_d, ms1_d;

    always_comb begin
        s1_sa  = rs1[W-1];
        s1_ea  = rs1[W-2:MW];
        s1_fa  = rs1[MW-1:0];
        s1_sb  = rs2[W-1] ^ op_sub;
        s1_eb  = rs2[W-2:MW];
        s1_fb  = rs2[MW-1:0];

        s1_a_nan = (&s1_ea) & (|s1_fa);
        s1_b_nan = (&s1_eb) & (|s1_fb);
        s1_a_inf = (&s1_ea) & ~(|s1_fa);
        s1_b_inf = (&s1_eb) & ~(|s1_fb);

        // Denormals: hidden bit 0 but same scale as exponent 1.
        s1_ma  = {|s1_ea, s1_fa};
        s1_mb  = {|s1_eb, s1_fb};
        s1_eaf = (|s1_ea) ? s1_ea : EW'(1);
        s1_ebf = (|s1_eb) ? s1_eb : EW'(1);

        s1_a_ge = {s1_eaf, s1_ma} >= {s1_ebf, s1_mb};
        if (s1_a_ge) begin
            sgn1_d  = s1_sa;
            s1_ebig = s1_eaf;
            s1_mbig = s1_ma;
            s1_esm  = s1_ebf;
            s1_msm  = s1_mb;
        end else begin
            sgn1_d  = s1_sb;
            s1_ebig = s1_ebf;
            s1_mbig = s1_mb;
            s1_esm  = s1_eaf;
            s1_msm  = s1_ma;
        end

        // Shifting by XW already pushes everything into sticky; cap keeps the shifter small.
        s1_diff = s1_ebig - s1_esm;
        s1_sh   = (32'(s1_diff) > 32'(XW)) ? 32'(XW) : 32'(s1_diff);
        s1_wide = {s1_msm, 2'b00, {XW{1'b0}}} >> s1_sh;
        ms1_d   = {s1_wide[2*XW-1:XW], |s1_wide[XW-1:0]};
        mb1_d   = {s1_mbig, 3'b000};

        sub1_d  = s1_sa ^ s1_sb;
        zs1_d   = s1_sa & s1_sb;
        spec1_d = s1_a_nan | s1_b_nan | s1_a_inf | s1_b_inf;

        if (s1_b_nan)
            specw1_d = {s1_sb, s1_eb, s1_fb | QBIT};
        else if (s1_a_nan)
            specw1_d = {s1_sa, s1_ea, s1_fa | QBIT};
        else if (s1_a_inf & s1_b_inf & (s1_sa != s1_sb))
            specw1_d = {1'b1, EONES, QBIT};
        else if (s1_a_inf)
            specw1_d = {s1_sa, EONES, {MW{1'b0}}};
        else
            specw1_d = {s1_sb, EONES, {MW{1'b0}}};
    end

    logic              v1_q, sgn1_q, sub1_q, zs1_q, spec1_q;
    logic [TAGW-1:0]   tag1_q;
    logic [W-1:0]      specw1_q;
    logic [EW-1:0]     e1_q;
    logic [MX-1:0]     mb1_q, ms1_q;

    // ---------------- stage 2: add/sub, normalise ----------------
    logic [MX:0]       s2_sum;
    logic [MX-1:0]     s2_mc;
    logic [EW-1:0]     s2_ec;
    logic [31:0]       s2_lzc, s2_lim, s2_nsh;
    logic [MX-1:0]     m2_d;
    logic [EW-1:0]     e2_d;
    logic              zero2_d;

    always_comb begin
        // Big operand is never smaller, so the subtraction cannot go negative.
        s2_sum = sub1_q ? ({1'b0, mb1_q} - {1'b0, ms1_q})
                        : ({1'b0, mb1_q} + {1'b0, ms1_q});
        if (s2_sum[MX]) begin
            s2_mc = {s2_sum[MX:2], s2_sum[1] | s2_sum[0]};
            s2_ec = e1_q + EW'(1);
        end else begin
            s2_mc = s2_sum[MX-1:0];
            s2_ec = s2_ec_pass(e1_q);
        end

        s2_lzc = 32'(MX);
        for (int i = 0; i < MX; i++) begin
            if (s2_mc[i])
                s2_lzc = 32'(MX - 1 - i);
        end

        // Never normalise below effective exponent 1; what remains is a denormal.
        s2_lim  = 32'(s2_ec) - 32'd1;
        s2_nsh  = (s2_lzc < s2_lim) ? s2_lzc : s2_lim;
        m2_d    = s2_mc << s2_nsh;
        e2_d    = s2_ec - EW'(s2_nsh);
        zero2_d = (s2_mc == '0);
    end

    function automatic logic [EW-1:0] s2_ec_pass(input logic [EW-1:0] e);
        return e;
    endfunction

    logic              v2_q, sgn2_q, zs2_q, spec2_q, zero2_q;
    logic [TAGW-1:0]   tag2_q;
    logic [W-1:0]      specw2_q;
    logic [EW-1:0]     e2_q;
    logic [MX-1:0]     m2_q;

    // ---------------- stage 3: round, pack, specials ----------------
    logic              s3_up, s3_hid;
    logic [MW+1:0]     s3_mr;
    logic [EW:0]       s3_er, s3_eo;
    logic [MW-1:0]     s3_frac;
    logic [W-1:0]      rd_d;

    always_comb begin
        s3_up = m2_q[2] & (m2_q[1] | m2_q[0] | m2_q[3]);
        s3_mr = {1'b0, m2_q[MX-1:3]} + (MW+2)'(s3_up);
        if (s3_mr[MW+1]) begin
            s3_frac = s3_mr[MW:1];
            s3_hid  = 1'b1;
            s3_er   = {1'b0, e2_q} + (EW+1)'(1);
        end else begin
            s3_frac = s3_mr[MW-1:0];
            s3_hid  = s3_mr[MW];
            s3_er   = {1'b0, e2_q};
        end
        // Hidden bit clear means denormal: stored exponent is 0.
        s3_eo = s3_hid ? s3_er : '0;

        if (spec2_q)
            rd_d = specw2_q;
        else if (zero2_q)
            rd_d = {zs2_q, {(W-1){1'b0}}};
        else if (s3_eo >= {1'b0, EONES})
            rd_d = {sgn2_q, EONES, {MW{1'b0}}};
        else
            rd_d = {sgn2_q, s3_eo[EW-1:0], s3_frac};
    end

    logic              v3_q;
    logic [TAGW-1:0]   tag3_q;
    logic [W-1:0]      rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; sgn1_q <= 1'b0; sub1_q <= 1'b0; zs1_q <= 1'b0; spec1_q <= 1'b0;
            tag1_q <= '0; specw1_q <= '0; e1_q <= '0; mb1_q <= '0; ms1_q <= '0;
            v2_q <= 1'b0; sgn2_q <= 1'b0; zs2_q <= 1'b0; spec2_q <= 1'b0; zero2_q <= 1'b0;
            tag2_q <= '0; specw2_q <= '0; e2_q <= '0; m2_q <= '0;
            v3_q <= 1'b0; tag3_q <= '0; rd_q <= '0;
        end else if (!stall) begin
            v1_q     <= in_valid;
            sgn1_q   <= sgn1_d;
            sub1_q   <= sub1_d;
            zs1_q    <= zs1_d;
            spec1_q  <= spec1_d;
            tag1_q   <= in_tag;
            specw1_q <= specw1_d;
            e1_q     <= s1_ebig;
            mb1_q    <= mb1_d;
            ms1_q    <= ms1_d;

            v2_q     <= v1_q;
            sgn2_q   <= sgn1_q;
            zs2_q    <= zs1_q;
            spec2_q  <= spec1_q;
            zero2_q  <= zero2_d;
            tag2_q   <= tag1_q;
            specw2_q <= specw1_q;
            e2_q     <= e2_d;
            m2_q     <= m2_d;

            v3_q     <= v2_q;
            tag3_q   <= tag2_q;
            rd_q     <= rd_d;
        end
    end

    assign out_valid = v3_q;
    assign rd        = rd_q;
    assign out_tag   = tag3_q;
endmodule

// File: tb/tb_fadd_pipe.sv
// Bench for fadd_pipe (EW=8, MW=23): directed vectors plus randomized traffic with random
// out_ready and a mid-stream reset, scored against a real-arithmetic reference model.
module tb_fadd_pipe;
    localparam int EW = 8, MW = 23, TAGW = 5;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] rs1, rs2, rd;
    logic [4:0]  in_tag, out_tag;

    always #5 clk = ~clk;

    fadd_pipe #(.EW(EW), .MW(MW), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .op_sub(op_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .out_tag(out_tag)
    );

    typedef struct {
        logic [31:0] word;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0, cyc = 0;
    bit          rnd_ready = 1'b0;
    logic [4:0]  tag_ctr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real f2r(input logic [31:0] w);
        int  e, k;
        real r;
        e = int'(w[30:23]);
        r = real'(int'({7'b0, e != 0, w[22:0]}));
        k = ((e == 0) ? 1 : e) - 150;
        for (int i = 0; i < k; i++) r = r * 2.0;
        for (int i = 0; i > k; i--) r = r / 2.0;
        return w[31] ? -r : r;
    endfunction

    // Round a nonzero double to the nearest-even single (double rounding is exact for one add).
    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d, sig, keep, mask;
        logic [31:0] word;
        int          ue, sh, base;
        bit          half, rest, up;
        d    = $realtobits(v);
        sig  = {11'b0, 1'b1, d[51:0]};
        ue   = int'(d[62:52]) - 1023;
        sh   = (ue >= -126) ? 29 : (-97 - ue);
        if (sh > 60) sh = 60;
        keep = sig >> sh;
        mask = (64'd1 << (sh - 1)) - 64'd1;
        half = sig[sh-1];
        rest = (sig & mask) != 64'd0;
        up   = half & (rest | keep[0]);
        keep = keep + 64'(up);
        base = (sh == 29) ? (ue + 126) : 0;
        word = (32'(base) << 23) + keep[31:0];
        if (word >= 32'h7F800000) word = 32'h7F800000;
        return {d[63], word[30:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [31:0] bs;
        bit          a_nan, b_nan, a_inf, b_inf;
        real         v;
        bs    = {b[31] ^ sub, b[30:0]};
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (b_nan) return bs | 32'h00400000;
        if (a_nan) return a | 32'h00400000;
        if (a_inf && b_inf) return (a[31] == bs[31]) ? a : 32'hFFC00000;
        if (a_inf) return a;
        if (b_inf) return bs;
        v = f2r(a) + f2r(bs);
        if (v == 0.0) return {a[31] & bs[31], 31'b0};
        return r2f(v);
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            6: case ($urandom_range(0, 5))
                   0: w = 32'h00000000;
                   1: w = 32'h80000000;
                   2: w = 32'h7F800000;
                   3: w = 32'hFF800000;
                   4: w = {w[31], 8'hFF, w[22:0] | 23'h1};
                   default: w = {w[31], 8'h00, w[22:0]};
               endcase
            7: w[30:23] = 8'h00;
            8: w[30:23] = 8'($urandom_range(1, 3));
            9: w[30:23] = 8'($urandom_range(250, 254));
            default: ;
        endcase
        return w;
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit          prev_stall;
        logic [31:0] prev_rd;
        logic [4:0]  prev_tag;
        exp_t        e;
        prev_stall = 1'b0;
        prev_rd    = '0;
        prev_tag   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_rd", rd, prev_rd);
                    chk("hold_tag", 32'(out_tag), 32'(prev_tag));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got rd %h tag %h, want no output", rd, out_tag);
                    end else begin
                        e = q.pop_front();
                        chk("rd", rd, e.word);
                        chk("tag", 32'(out_tag), 32'(e.tag));
                        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_rd    = rd;
                prev_tag   = out_tag;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] expw, input bit lat);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        rs1 = a; rs2 = b; op_sub = sub; in_tag = tag_ctr; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{expw, in_tag, cyc, lat});
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready 0 for %0d cycles, want 1", n);
                break;
            end
            @(posedge clk);
            #1;
        end
        tag_ctr++;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    logic [31:0] dir_a [11] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800001,
                                32'h7F7FFFFF, 32'h00000001, 32'h00800000, 32'h7F800000, 32'h7FC00001,
                                32'h7F800001};
    logic [31:0] dir_b [11] = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h33800000, 32'h33800000,
                                32'h7F7FFFFF, 32'h00000001, 32'h00000001, 32'hFF800000, 32'h3F800000,
                                32'h7F800000};
    logic        dir_s [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] dir_r [11] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800002,
                                32'h7F800000, 32'h00000002, 32'h007FFFFF, 32'hFFC00000, 32'h7FC00001,
                                32'h7FC00001};

    initial begin : stim
        logic [31:0] a, b;
        logic        s;
        rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; op_sub = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();

        rnd_ready = 1'b0;
        for (int i = 0; i < 11; i++)
            send(dir_a[i], dir_b[i], dir_s[i], dir_r[i], 1'b1);
        idle();
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 5) == 0) idle();
            a = rnd_word();
            if ($urandom_range(0, 2) == 0) begin
                b = a ^ 32'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) b[23] = ~b[23];
                b[31] = 1'($urandom_range(0, 1));
            end else begin
                b = rnd_word();
            end
            s = 1'($urandom_range(0, 1));
            send(a, b, s, ref_add(a, b, s), 1'b0);
        end
        idle();
        rnd_ready = 1'b0;
        drain();
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
